// File: rtl/mcp_control_fsm_pkg.sv
// mcp_defs: shared encodings for the multicycle MIPS control path and ALU
package mcp_defs;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SLLV = 4'd4;
    localparam logic [3:0] ALU_SRLV = 4'd5;
    localparam logic [3:0] ALU_SRAV = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_XNOR = 4'd10;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SLLV   = 6'h04;
    localparam logic [5:0] F_SRLV   = 6'h06;
    localparam logic [5:0] F_SRAV   = 6'h07;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_XOR    = 6'h26;
    localparam logic [5:0] F_XNOR   = 6'h27;
    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_4     = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC_R  = 4'd7,
        S_ALUWB   = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_TRAP    = 4'd14
    } state_t;
endpackage

// File: rtl/mcp_alu_decoder.sv
// mcp_alu_decoder: R-type Funct to ALU operation, arithmetic and illegal flags
module mcp_alu_decoder
    import mcp_defs::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alusel,
    output logic       is_arith,
    output logic       illegal
);
    always_comb begin
        alusel  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            F_ADD:   alusel = ALU_ADD;
            F_SUB:   alusel = ALU_SUB;
            F_SLL:   alusel = ALU_SLL;
            F_SRL:   alusel = ALU_SRL;
            F_SLLV:  alusel = ALU_SLLV;
            F_SRLV:  alusel = ALU_SRLV;
            F_SRAV:  alusel = ALU_SRAV;
            F_AND:   alusel = ALU_AND;
            F_OR:    alusel = ALU_OR;
            F_XOR:   alusel = ALU_XOR;
            F_XNOR:  alusel = ALU_XNOR;
            default: illegal = 1'b1;
        endcase
    end
    assign is_arith = funct == F_ADD || funct == F_SUB;
endmodule

// File: rtl/mcp_control_fsm.sv
// mcp_control_fsm: multicycle MIPS main control FSM with trap and retire counter
module mcp_control_fsm
    import mcp_defs::*;
#(
    parameter int CW = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [5:0]    Opcode,
    input  logic [5:0]    Funct,
    input  logic          zero,
    input  logic          OVF_F,
    output logic          IorD,
    output logic          MemWrite,
    output logic          IRWrite,
    output logic          RegDst,
    output logic          MemtoReg,
    output logic          RegWrite,
    output logic          ALUSrcA,
    output logic [1:0]    ALUSrcB,
    output logic [3:0]    ALUSel,
    output logic [1:0]    PCSrc,
    output logic          PCEn,
    output logic          Exception,
    output logic [3:0]    StateOut,
    output logic [CW-1:0] InstrCount
);
    state_t state, next;
    logic retire, dec_arith, dec_illegal;
    logic [3:0] dec_sel;

    mcp_alu_decoder u_dec (
        .funct   (Funct),
        .alusel  (dec_sel),
        .is_arith(dec_arith),
        .illegal (dec_illegal)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_RESET;
            InstrCount <= '0;
        end else begin
            state <= next;
            if (retire) InstrCount <= InstrCount + CW'(1);
        end
    end

    always_comb begin
        next      = state;
        retire    = 1'b0;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_B;
        ALUSel    = ALU_ADD;
        PCSrc     = PC_ALU;
        PCEn      = 1'b0;
        Exception = 1'b0;
        case (state)
            S_RESET:  next = S_FETCH;
            S_FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = SRCB_4;
                PCEn    = 1'b1;
                next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                next = Opcode == OP_RTYPE ? S_EXEC_R :
                       (Opcode == OP_LW || Opcode == OP_SW) ? S_MEMADR :
                       (Opcode == OP_BEQ || Opcode == OP_BNE) ? S_BRANCH :
                       Opcode == OP_ADDI ? S_ADDI_EX :
                       Opcode == OP_J ? S_JUMP : S_TRAP;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = Opcode == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                next = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                next     = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
                next     = S_FETCH;
            end
            // overflowing add/sub trap here so the writeback state is never reached
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSel  = dec_sel;
                next    = (dec_illegal || (dec_arith && OVF_F)) ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                next     = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = OVF_F ? S_TRAP : S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUSel  = ALU_SUB;
                PCSrc   = PC_ALUOUT;
                PCEn    = zero ^ (Opcode == OP_BNE);
                retire  = 1'b1;
                next    = S_FETCH;
            end
            S_JUMP: begin
                PCSrc  = PC_JUMP;
                PCEn   = 1'b1;
                retire = 1'b1;
                next   = S_FETCH;
            end
            S_TRAP: begin
                Exception = 1'b1;
                next      = S_TRAP;
            end
            default: next = S_TRAP;
        endcase
    end

    assign StateOut = state;
endmodule
